mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  Execute-stage request; sampled on the rising clk edge.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port A  input  32  operand rs (forwarded value from Execute).
REQ-008 SHALL have port B  input  32  operand rt (forwarded value from Execute).
REQ-009 SHALL have port busy  output  1  operation in flight; hazard unit stalls MDU-using instructions in D.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1) with a down-counter.
REQ-013 start SHALL be accepted only in IDLE; a start while busy=1 SHALL be ignored, with no effect on counter, HI or LO.
REQ-014 MTHI/MTLO accepted SHALL write A to HI/LO at that edge; busy stays 0; the other register is unchanged.
REQ-015 MULT/DIV accepted SHALL latch A and B, load the counter, and move to RUN; busy SHALL be 1 for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-016 HI/LO SHALL update at the edge that returns the FSM to IDLE, i.e. exactly N cycles after the start edge; busy falls at that same edge.
REQ-017 The result SHALL be computed from the latched operands; changes on A, B, op or start during RUN SHALL have no effect.
REQ-018 MULT SHALL be a signed 32x32->64 multiply; MULTU SHALL be unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-019 DIV SHALL give LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL be unsigned.
REQ-020 For divisor 0, the block SHALL still run DIV_CYCLES, and HI and LO SHALL be left unchanged.
REQ-021 For signed 0x80000000 / 0xFFFFFFFF, the block SHALL give LO = 0x80000000 and HI = 0.
REQ-022 Ops 6-7 SHALL be no-ops and SHALL leave busy low.
REQ-023 A new start SHALL be accepted in the first cycle that busy reads 0.
REQ-024 HI, LO and busy SHALL all be register outputs, with no combinational path from inputs.

Reset
REQ-025 While reset=0, HI = 0, LO = 0, busy = 0, counter = 0 and FSM = IDLE, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no result is committed after release.

Configuration
REQ-027 With macro MDU_DIV_EN defined, DIV/DIVU SHALL behave as described in REQ-015 to REQ-021.
REQ-028 Without MDU_DIV_EN, DIV/DIVU SHALL be no-ops: busy stays 0, HI/LO are unchanged, and no divider logic is synthesised.

Structure
REQ-029 Shared package mdu_pkg SHALL hold the op encoding constants and the default MULT_CYCLES/DIV_CYCLES values.
REQ-030 Division SHALL live in sub-module mdu_divider (signed/unsigned quotient/remainder), instantiated only under MDU_DIV_EN.
REQ-031 Multiply, FSM, counter and HI/LO registers SHALL live in mdu_unit itself.

Verification
REQ-032 MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; start pulsed during busy is ignored.
REQ-034 DIV A=-7, B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with B=0 -> HI/LO unchanged.
REQ-035 MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 back-to-back -> HI/LO updated at each edge with busy=0 throughout.
REQ-036 Start MULT, assert reset at cycle 3 -> HI=LO=0 and busy=0 immediately, and stay so after release.
REQ-037 Build without MDU_DIV_EN and issue DIV -> busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encoding and default latencies for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign. A zero divisor yields don't-care values.
module mdu_divider (
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Work on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        neg_a = signed_i & dividend_i[31];
        neg_b = signed_i & divisor_i[31];
        mag_a = neg_a ? (32'd0 - dividend_i) : dividend_i;
        mag_b = neg_b ? (32'd0 - divisor_i) : divisor_i;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        q_mag = mag_a / mag_b;
        r_mag = mag_a % mag_b;
        quo_o = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem_o = neg_a ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit; MULT/DIV hold busy for a fixed
// cycle count, MTHI/MTLO write in one edge. Starts while busy are dropped. MDU_DIV_EN enables DIV/DIVU.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
`endif

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        accept;
    logic        start_mul;
    logic        start_div;
    logic [63:0] prod;

    assign accept    = start && (state_q == ST_IDLE);
    assign start_mul = accept && is_mul_op(op);
`ifdef MDU_DIV_EN
    assign start_div = accept && is_div_op(op);

    logic [31:0] quo;
    logic [31:0] rem;

    mdu_divider u_div (
        .dividend_i (a_q),
        .divisor_i  (b_q),
        .signed_i   (op_q == OP_DIV),
        .quo_o      (quo),
        .rem_o      (rem)
    );
`else
    assign start_div = 1'b0;
`endif

    // Sign-extend for MULT so the truncated 64-bit product is the signed result.
    always_comb begin
        if (op_q == OP_MULTU) begin
            prod = {32'd0, a_q} * {32'd0, b_q};
        end else begin
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (accept && (op == OP_MTHI)) begin
                hi_d = A;
            end
            if (accept && (op == OP_MTLO)) begin
                lo_d = A;
            end
            if (start_mul || start_div) begin
                state_d = ST_RUN;
                op_d    = op;
                a_d     = A;
                b_d     = B;
`ifdef MDU_DIV_EN
                cnt_d   = start_mul ? MULT_LOAD : DIV_LOAD;
`else
                cnt_d   = MULT_LOAD;
`endif
            end
        end else begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (is_mul_op(op_q)) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
`ifdef MDU_DIV_EN
                else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
`endif
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed plus random stimulus for mdu_unit against an arithmetic reference model.
module tb_mdu_unit;

    localparam int N_MUL = 5;
    localparam int N_DIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag, input logic exp_busy);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
        chk({tag, ".hi"}, HI, exp_hi);
        chk({tag, ".lo"}, LO, exp_lo);
    endtask

    // Caller is positioned at a negedge; returns at the negedge where busy has just fallen.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] nh;
        logic [31:0] nl;
        longint      sp;
        longint      sq;
        longint      sr;
        longint unsigned up;
        n  = 0;
        nh = exp_hi;
        nl = exp_lo;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                n = N_MUL; nh = sp[63:32]; nl = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                n = N_MUL; nh = up[63:32]; nl = up[31:0];
            end
`ifdef MDU_DIV_EN
            3'd2, 3'd3: begin
                n = N_DIV;
                if (b != 32'd0) begin
                    if (o == 3'd2) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        sq = longint'({32'd0, a}) / longint'({32'd0, b});
                        sr = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    nh = sr[31:0]; nl = sq[31:0];
                end
            end
`endif
            3'd4: nh = a;
            3'd5: nl = a;
            default: ;
        endcase
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            chk_state({tag, ".run"}, 1'b1);
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            A     = $urandom;
            B     = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        exp_hi = nh;
        exp_lo = nl;
        chk_state({tag, ".done"}, 1'b0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        #1;
        chk_state("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg.hi_abs", HI, 32'hFFFF_FFFF);
        chk("mult_neg.lo_abs", LO, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("multu.hi_abs", HI, 32'h0000_0001);
        chk("multu.lo_abs", LO, 32'hFFFF_FFFE);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
        run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
        chk("mt.hi_abs", HI, 32'h1234_5678);
        chk("mt.lo_abs", LO, 32'h9ABC_DEF0);
        run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1);
        run_op("nop7", 3'd7, 32'hCAFE_F00D, 32'd1);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
`ifdef MDU_DIV_EN
        chk("div.lo_abs", LO, 32'hFFFF_FFFD);
        chk("div.hi_abs", HI, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_abs", LO, 32'h8000_0000);
        chk("div_ovf.hi_abs", HI, 32'h0000_0000);
`else
        chk("nodiv.hi_abs", HI, 32'h1234_5678);
        chk("nodiv.lo_abs", LO, 32'h9ABC_DEF0);
`endif
        run_op("divu_zero", 3'd3, 32'h0000_0064, 32'd0);
        run_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick_val(), pick_val());
        end

        run_op("pre_rst", 3'd1, 32'h0001_0001, 32'h0003_0003);
        start = 1'b1; op = 3'd0; A = 32'h0000_0007; B = 32'h0000_0009;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk_state("rst_mid", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
        end
        chk_state("rst_after", 1'b0);
        run_op("post_rst", 3'd0, 32'h0000_0007, 32'h0000_0009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
